// File: rtl/block_data_memory_if.sv
// Block-level bus between the data cache (master) and the block data memory (slave).
// Carries the read/write requests, block address, write data, read data and busywait.
interface block_data_memory_if;
  logic        read;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/block_data_memory.sv
// 64 x 32-bit block memory with a fixed LATENCY-cycle access and busywait handshake.
// Optional BLOCK_MEM_RESET_CLEAR_EN: reset also clears every block to zero.
module block_data_memory #(
  parameter int LATENCY = 5
) (
  input  logic                clock,
  input  logic                reset,
  block_data_memory_if.slave  bus
);

  localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  count_reg;
  logic        op_write_reg;
  logic [5:0]  address_reg;
  logic [31:0] writedata_reg;
  logic [31:0] readdata_reg;
  logic        busywait_next;
  logic [31:0] mem [64];

  logic request_valid;
  logic accept;
  logic access_done;

  // read && write together is illegal and treated as no request.
  assign request_valid = bus.read ^ bus.write;
  assign accept        = (state_reg == IDLE) && request_valid;
  assign access_done   = (state_reg == ACCESS) && (count_reg == 8'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (request_valid) state_next = ACCESS;
      ACCESS:  if (count_reg == 8'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busywait_next = 1'b0;
    if (reset) begin
      case (state_reg)
        IDLE:    busywait_next = request_valid;
        ACCESS:  busywait_next = 1'b1;
        DONE:    busywait_next = 1'b0;
        default: busywait_next = 1'b0;
      endcase
    end
  end

  // Request is captured at acceptance so bus changes during ACCESS are ignored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg     <= 8'd0;
      op_write_reg  <= 1'b0;
      address_reg   <= 6'd0;
      writedata_reg <= 32'h0;
      readdata_reg  <= 32'h0;
    end else begin
      if (accept) begin
        count_reg     <= LOAD_COUNT;
        op_write_reg  <= bus.write;
        address_reg   <= bus.address;
        writedata_reg <= bus.writedata;
      end else if (state_reg == ACCESS && count_reg != 8'd0) begin
        count_reg <= count_reg - 8'd1;
      end
      if (access_done && !op_write_reg) begin
        readdata_reg <= mem[address_reg];
      end
    end
  end

`ifdef BLOCK_MEM_RESET_CLEAR_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (access_done && op_write_reg) begin
      mem[address_reg] <= writedata_reg;
    end
  end
`else
  // Reset gates the write so an aborted access never reaches the array.
  always_ff @(posedge clock) begin
    if (reset && access_done && op_write_reg) begin
      mem[address_reg] <= writedata_reg;
    end
  end
`endif

  assign bus.readdata = readdata_reg;
  assign bus.busywait = busywait_next;

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: a driver pushes expected results from a
// plain array model, a monitor pops and compares on each busywait fall.
module tb_block_data_memory;

  localparam int LAT = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  block_data_memory_if bus ();
  block_data_memory_if bus1 ();

  block_data_memory #(.LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  block_data_memory #(.LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] model_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int   busy_cnt;
    bit   prev_busy;
    exp_t e;
    busy_cnt  = 0;
    prev_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (bus.busywait) begin
          busy_cnt++;
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got readdata %h, expected no completion", bus.readdata);
          end else begin
            e = exp_q.pop_front();
            $display("txn %s addr=%h readdata=%h busy_cycles=%0d", e.is_write ? "WR" : "RD",
                     e.addr, bus.readdata, busy_cnt);
            check32(e.is_write ? "readdata_after_write" : "readdata_after_read", bus.readdata, e.rdata);
            check32("access_cycles", 32'(busy_cnt), 32'(LAT));
          end
          busy_cnt = 0;
        end
        prev_busy = bus.busywait;
      end
    end
  end

  task automatic access(input bit is_write, input logic [5:0] addr, input logic [31:0] data,
                        input bit disturb);
    exp_t e;
    int   n;
    @(negedge clock);
    bus.read      = !is_write;
    bus.write     = is_write;
    bus.address   = addr;
    bus.writedata = data;
    e.is_write = is_write;
    e.addr     = addr;
    if (is_write) begin
      e.rdata         = model_rd;
      model_mem[addr] = data;
    end else begin
      model_rd = model_mem[addr];
      e.rdata  = model_rd;
    end
    exp_q.push_back(e);
    #1;
    check32("busy_in_request_cycle", {31'b0, bus.busywait}, 32'd1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (disturb && n == 1) begin
        bus.address   = 6'h06;
        bus.writedata = 32'h0000_0001;
      end
    end while (bus.busywait && n < 40);
    if (bus.busywait) begin
      checks++;
      errors++;
      $display("FAIL busywait_timeout: got busywait 1 after %0d cycles, expected 0", n);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  // Write of A5A5A5A5 to 6'h10 aborted by reset in the given ACCESS cycle.
  task automatic abort_write(input int access_cycle);
    @(negedge clock);
    bus.write     = 1'b1;
    bus.address   = 6'h10;
    bus.writedata = 32'hA5A5_A5A5;
    repeat (access_cycle) @(negedge clock);
    reset = 1'b0;
    #1;
    check32("busy_in_reset_cycle", {31'b0, bus.busywait}, 32'd0);
    @(negedge clock);
    reset     = 1'b1;
    bus.write = 1'b0;
    model_rd  = 32'h0;
`ifdef BLOCK_MEM_RESET_CLEAR_EN
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
`endif
    check32("readdata_after_reset", bus.readdata, 32'h0);
  endtask

  initial begin
    logic [5:0]  a;
    logic [31:0] d1;
    bit          pat [5];
    int          n;

    bus.read = 1'b1;  // request during reset must not raise busywait
    bus.write = 1'b0;
    bus.address = 6'h00;
    bus.writedata = 32'h0;
    bus1.read = 1'b0;
    bus1.write = 1'b0;
    bus1.address = 6'h00;
    bus1.writedata = 32'h0;
    model_rd = 32'h0;

    repeat (3) @(posedge clock);
    #1;
    check32("reset_busywait", {31'b0, bus.busywait}, 32'd0);
    check32("reset_readdata", bus.readdata, 32'h0);
    bus.read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

`ifdef BLOCK_MEM_RESET_CLEAR_EN
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    access(1'b0, 6'h00, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 64; i++) access(1'b1, 6'(i), $urandom, 1'b0);
    access(1'b0, 6'h00, 32'h0, 1'b0);

    access(1'b1, 6'h2A, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 6'h2A, 32'h0, 1'b0);

    access(1'b1, 6'h05, $urandom, 1'b1);
    access(1'b0, 6'h05, 32'h0, 1'b0);
    access(1'b0, 6'h06, 32'h0, 1'b0);

    a = 6'($urandom_range(63));
    @(negedge clock);
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.address   = a;
    bus.writedata = $urandom;
    #1;
    check32("illegal_busy_now", {31'b0, bus.busywait}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check32("illegal_busy_held", {31'b0, bus.busywait}, 32'd0);
    end
    @(negedge clock);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    access(1'b0, a, 32'h0, 1'b0);

    abort_write(3);
    access(1'b0, 6'h10, 32'h0, 1'b0);
    abort_write(LAT);
    access(1'b0, 6'h10, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      access(1'($urandom_range(1)), 6'($urandom_range(63)), $urandom, 1'b0);
    end

    // LATENCY=1 instance: one write, then a read held across two acceptances.
    d1 = $urandom;
    @(negedge clock);
    bus1.write     = 1'b1;
    bus1.address   = 6'h03;
    bus1.writedata = d1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus1.busywait && n < 20);
    bus1.write = 1'b0;
    @(negedge clock);
    bus1.read = 1'b1;
    #1;
    check32("lat1_busy_request", {31'b0, bus1.busywait}, 32'd1);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check32("lat1_busy_pattern", {31'b0, bus1.busywait}, {31'b0, pat[k]});
      if (!pat[k]) check32("lat1_readdata", bus1.readdata, d1);
    end
    @(negedge clock);
    bus1.read = 1'b0;
    @(posedge clock);
    #1;
    check32("lat1_idle_after", {31'b0, bus1.busywait}, 32'd0);

    repeat (5) @(posedge clock);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
